// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared widths and state encoding for the PWM fade sequencer.
package pwm_fade_ctrl_pkg;

  localparam int BRIGHTNESS_WIDTH = 7;
  localparam int FADE_RATE_WIDTH  = 8;

  typedef enum logic {
    FADE_IDLE = 1'b0,
    FADE_RAMP = 1'b1
  } fade_state_t;

endpackage

// File: rtl/pwm_fade_ctrl.sv
// Brightness fade sequencer: ramps the pwm duty one LSB at a time toward a
// commanded target, only ever updating the duty at a PWM period boundary.
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int BW     = BRIGHTNESS_WIDTH,
  parameter int RATE_W = FADE_RATE_WIDTH
) (
  input  logic              sysclk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [BW-1:0]     i_cmd_target,
  input  logic [RATE_W-1:0] i_cmd_rate,
  input  logic [BW-1:0]     i_cnt,
  output logic              o_enb,
  output logic [BW-1:0]     o_d,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [BW-1:0]     D_ONE    = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [RATE_W-1:0] RATE_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

  fade_state_t       state_reg;
  logic [BW-1:0]     target_reg;
  logic [RATE_W-1:0] rate_reg;
  logic [RATE_W-1:0] pcnt_reg;
  logic              boundary;

  // A disabled pwm parks its counter at all-ones, so boundary stays true then.
  assign boundary    = (i_cnt == {BW{1'b1}});
  assign o_cmd_ready = (state_reg == FADE_IDLE);
  assign o_busy      = (state_reg == FADE_RAMP);

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= FADE_IDLE;
      target_reg <= '0;
      rate_reg   <= '0;
      pcnt_reg   <= '0;
      o_d        <= '0;
      o_enb      <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        FADE_IDLE: begin
          if (i_cmd_valid) begin
            target_reg <= i_cmd_target;
            rate_reg   <= i_cmd_rate;
            pcnt_reg   <= '0;
            state_reg  <= FADE_RAMP;
            if (i_cmd_target != '0) begin
              o_enb <= 1'b1;
            end
          end
        end
        FADE_RAMP: begin
          if (boundary) begin
            if (o_d == target_reg) begin
              state_reg <= FADE_IDLE;
              o_done    <= 1'b1;
              if (target_reg == '0) begin
                o_enb <= 1'b0;
              end
            end else if (rate_reg == '0) begin
              o_d <= target_reg;
            end else if (pcnt_reg == rate_reg) begin
              // o_d moves toward target and stops on equality, so it never wraps.
              o_d      <= (o_d < target_reg) ? (o_d + D_ONE) : (o_d - D_ONE);
              pcnt_reg <= '0;
            end else begin
              pcnt_reg <= pcnt_reg + RATE_ONE;
            end
          end
        end
        default: state_reg <= FADE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl with a behavioural pwm counter closing the i_cnt loop.
module tb_pwm_fade_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_target;
  logic [7:0] cmd_rate;
  logic [6:0] cnt;
  logic       enb;
  logic [6:0] d;
  logic       busy;
  logic       done;
  logic       pwm_out;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_fade_ctrl dut (
    .sysclk       (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_target (cmd_target),
    .i_cmd_rate   (cmd_rate),
    .i_cnt        (cnt),
    .o_enb        (enb),
    .o_d          (d),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal pwm: counter free-runs while enabled, parks at all-ones when off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= 7'h7f;
    else if (enb) cnt <= cnt + 7'd1;
    else          cnt <= 7'h7f;
  end
  assign pwm_out = enb && (cnt < d);

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // o_d may only move on the edge that closes a cnt==127 cycle.
  logic [6:0] d_prev;
  logic [6:0] cnt_prev;
  logic       rst_prev;
  initial begin
    d_prev = '0; cnt_prev = 7'h7f; rst_prev = 1'b0;
  end
  always @(negedge clk) begin
    if (rst_n && rst_prev && d != d_prev) begin
      n_tests++;
      if (cnt_prev != 7'h7f) begin
        n_fail++;
        $display("FAIL d_off_boundary: d %0d->%0d with prior cnt %0d, expected cnt 127",
                 d_prev, d, cnt_prev);
      end
    end
    d_prev   = d;
    cnt_prev = cnt;
    rst_prev = rst_n;
  end

  // Call at posedge+1 in IDLE; returns at posedge+1 right after acceptance.
  task automatic send(input logic [6:0] t, input logic [7:0] r);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_rate   = r;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
  endtask

  // Counts boundaries seen in RAMP up to and including the completing one.
  task automatic wait_done(output int nb);
    bit ok;
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (cnt == 7'h7f) nb++;
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", int'(ok), 1);
  endtask

  typedef struct {
    logic [6:0] target;
    logic [7:0] rate;
    int         exp_nb;
    logic [6:0] exp_d;
    logic       exp_enb;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int nb;
    int hi;
    logic [6:0] last_d;

    // Chained: each vector starts from the previous vector's final duty.
    vecs[0] = '{7'd32, 8'd0, 2,  7'd32, 1'b1};
    vecs[1] = '{7'd36, 8'd1, 9,  7'd36, 1'b1};
    vecs[2] = '{7'd33, 8'd2, 10, 7'd33, 1'b1};
    vecs[3] = '{7'd33, 8'd5, 1,  7'd33, 1'b1};
    vecs[4] = '{7'd30, 8'd0, 2,  7'd30, 1'b1};
    vecs[5] = '{7'd0,  8'd0, 2,  7'd0,  1'b0};
    vecs[6] = '{7'd0,  8'd3, 1,  7'd0,  1'b0};
    vecs[7] = '{7'd3,  8'd0, 2,  7'd3,  1'b1};
    vecs[8] = '{7'd0,  8'd1, 7,  7'd0,  1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_target = '0; cmd_rate = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_d", d, 0);
    chk("rst_enb", enb, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Enable rises on the acceptance edge for a nonzero target.
    send(7'd32, 8'd0);
    chk("accept_enb", enb, 1);
    chk("accept_busy", busy, 1);
    chk("accept_d", d, 0);
    wait_done(nb);
    chk("jump_nb", nb, 2);
    chk("jump_d", d, 32);
    @(posedge clk); #1;
    chk("done_pulse_len", done, 0);
    hi = 0;
    for (int i = 0; i < 128; i++) begin
      if (pwm_out) hi++;
      @(posedge clk); #1;
    end
    chk("duty32_high", hi, 32);
    $display("[TB] jump 0->32: boundaries=%0d high=%0d/128", nb, hi);

    for (int v = 1; v < 9; v++) begin
      send(vecs[v].target, vecs[v].rate);
      wait_done(nb);
      chk($sformatf("v%0d_nb", v), nb, vecs[v].exp_nb);
      chk($sformatf("v%0d_d", v), d, vecs[v].exp_d);
      chk($sformatf("v%0d_enb", v), enb, vecs[v].exp_enb);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready", v), cmd_ready, 1);
      if (!vecs[v].exp_enb) begin
        chk($sformatf("v%0d_cnt_park", v), cnt, 127);
        chk($sformatf("v%0d_pwm_off", v), pwm_out, 0);
      end
      $display("[TB] vec %0d target=%0d rate=%0d boundaries=%0d d=%0d enb=%0d",
               v, vecs[v].target, vecs[v].rate, nb, d, enb);
    end

    // Ramp 0->4 rate 1 while a competing command is held valid.
    send(7'd4, 8'd1);
    cmd_valid = 1'b1; cmd_target = 7'd100; cmd_rate = 8'd0;
    nb = 0; last_d = d;
    for (int i = 0; i < 4000; i++) begin
      if (cnt == 7'h7f) nb++;
      @(posedge clk); #1;
      if (d != last_d) begin
        chk("step_boundary", nb, 2 * int'(d));
        chk("busy_ready", cmd_ready, 0);
        last_d = d;
      end
      if (done) break;
    end
    chk("busy_done", done, 1);
    chk("busy_nb", nb, 9);
    chk("busy_d", d, 4);
    chk("busy_done_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("held_accepted", busy, 1);
    wait_done(nb);
    chk("held_d", d, 100);
    chk("held_nb", nb, 2);
    $display("[TB] held command: target=100 boundaries=%0d d=%0d", nb, d);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a slow ramp.
    send(7'd127, 8'd3);
    repeat (1500) @(posedge clk);
    #1;
    chk("midramp_moving", int'(d > 7'd100), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d", d, 0);
    chk("arst_enb", enb, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_cnt", cnt, 127);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(7'd5, 8'd0);
    wait_done(nb);
    chk("post_rst_d", d, 5);
    chk("post_rst_nb", nb, 2);
    $display("[TB] reset recovery: target=5 boundaries=%0d d=%0d", nb, d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Sequencer that owns the `pwm` block's i_enb/i_d inputs.
- Accepts a brightness command (target duty, ramp rate) over a valid/ready handshake.
- Ramps the duty one LSB at a time, changing it only at PWM period boundaries so no period is ever truncated.
- Sits between the SPI register front-end (command source) and the `pwm` instance.

Parameters:
- BW, `BRIGHTNESS_WIDTH (7): duty/counter width; PWM period is 2**BW clocks.
- RATE_W, 8: width of the ramp-rate field.

Ports:
- sysclk  in  1  system clock, all logic rising-edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  controller can accept a command.
- i_cmd_target  in  BW  target duty (0..2**BW-1).
- i_cmd_rate  in  RATE_W  PWM periods per duty step, minus one.
- i_cnt  in  BW  pwm o_cnt (period counter feedback).
- o_enb  out  1  to pwm i_enb.
- o_d  out  BW  to pwm i_d.
- o_busy  out  1  ramp in progress.
- o_done  out  1  one-cycle pulse: target reached.

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_d=0, o_enb=0, o_busy=0, o_done=0, o_cmd_ready=1, internal target=0, rate=0, period count pcnt=0.
- boundary = (i_cnt == 2**BW-1). While the pwm is disabled it holds cnt at all-ones, so boundary is then permanently true.
- o_cmd_ready = (state==IDLE), combinational from the state register. o_busy = (state==RAMP).
- IDLE:
  - On i_cmd_valid & o_cmd_ready: latch target and rate, pcnt=0, state->RAMP.
  - If target != 0, set o_enb=1 in the same edge.
  - o_d does not change on acceptance.
- RAMP: evaluated only on cycles where boundary=1; non-boundary cycles hold everything.
  - If o_d == target: state->IDLE, o_done=1 for the next cycle. If target==0, also o_enb->0 on the same edge.
  - Else if rate == 0: o_d = target (jump).
  - Else if pcnt == rate: o_d = o_d±1 toward target, pcnt=0.
  - Else: pcnt = pcnt+1.
  - Result: one step every rate+1 boundaries, and completion is detected at the boundary after the final step. Ramp from a to b with rate r ends |a-b|·(r+1)+1 boundaries after acceptance (rate 0: 2 boundaries).
- Direction: o_d < target increments; o_d > target decrements. No wrap-around is possible, because o_d steps toward target and stops when equal.
- Commands arriving in RAMP are not accepted (ready=0); the source must hold valid. There is no queueing.
- Command with target == current o_d: accepted; done at the first boundary; o_d is unchanged.
- o_done and a new acceptance may coincide: o_done is high in the first IDLE cycle, which is also the first cycle ready=1.
- Reset mid-ramp: all outputs return to reset values immediately; the pwm is disabled.
- The controller exists to guarantee that o_d never changes on a non-boundary cycle.
- All outputs are registered except o_cmd_ready/o_busy, which are state decodes.

Decomposition:
- params.vh already holds BRIGHTNESS_WIDTH and CLK_NS. Add FADE_RATE_WIDTH (8) and state encodings FADE_IDLE=1'b0, FADE_RAMP=1'b1.
- No sub-module needed; the step logic stays inline.
- The bench instantiates pwm_fade_ctrl with `pwm` closing the i_cnt loop.

Test Plan:
- Reset: release i_rst_n -> o_d=0, o_enb=0, o_cmd_ready=1, o_busy=0, o_done=0; assert i_rst_n low mid-clock -> outputs clear without a clock edge.
- Jump: cmd target=32 rate=0 from o_d=0 -> o_enb=1 next edge; o_d=32 at first boundary; o_done pulse at the following boundary (128 clocks later); pwm high 32 clocks per period afterward.
- Ramp up: target=4 rate=1 from 0 -> o_d reaches 1,2,3,4 at boundaries 2,4,6,8; o_done after boundary 9; o_d changes only when o_cnt==127.
- Ramp down to off: from 3, target=0 rate=0 -> o_d=0 at first boundary; o_enb=0 with o_done at the next; pwm o_cnt returns to 127 and o_pwm=0.
- Busy rejection: issue target=100 while ramping to 4 -> ready=0, command ignored until done; the held-valid command is accepted in the done cycle.
- Reset mid-ramp: assert i_rst_n low during ramp 0->127 rate=3 -> o_d=0, o_enb=0, state IDLE; a new command after release is accepted normally.
